adc_hamming_encoder: RTL and testbench
======================================

Name: adc_hamming_encoder

Overview:
Stage directly downstream of the flash-ADC priority encoder. Captures each 3-bit binary sample on a sample strobe, encodes it into a shortened Hamming(6,3) codeword and tags it with a wrapping sequence number. Buffers the results in a small FIFO and presents them on a valid/ready interface to the channel/error-injection stage. Counts samples dropped due to back-pressure.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
SEQ_W, 4, width of the per-sample sequence tag
OVF_W, 8, width of the saturating overflow counter

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
sample_valid  input  1  binary_in is a new sample this cycle
binary_in  input  3  sample from priority encoder (d2..d0 = bits 2..0)
code_valid  output  1  FIFO head is valid
code_ready  input  1  consumer accepts head this cycle
code_out  output  6  Hamming(6,3) codeword of head; bit i-1 = Hamming position i
seq_out  output  SEQ_W  sequence tag of head
fifo_full  output  1  FIFO holds DEPTH entries
overflow_cnt  output  OVF_W  saturating count of dropped samples

Behaviour:
- Reset (async assert, sync release on clk): FIFO empty, pointers 0, code_valid=0, code_out=0, seq_out=0, fifo_full=0, overflow_cnt=0, sequence counter=0.
- Encoding (combinational at FIFO write side): positions 1..6 = p1, p2, d0, p4, d1, d2; p1=d0^d1, p2=d0^d2, p4=d1^d2. code_out = {d2,d1,p4,d0,p2,p1}.
- Push: sample_valid=1 and (not full, or full with simultaneous pop) -> store {codeword, seq}; sequence counter +1, wraps modulo 2^SEQ_W.
- Drop: sample_valid=1, full, no pop -> sample discarded, sequence counter unchanged, overflow_cnt +1, saturating at all-ones.
- Pop: code_valid=1 and code_ready=1 on a rising edge.
- Latency: sample accepted at edge N into empty FIFO -> code_valid=1, correct code_out/seq_out after edge N (1 cycle). No combinational path from sample_valid/binary_in to outputs.
- Outputs come from the FIFO head (registered storage + read pointer); code_out/seq_out hold stable while code_valid=1 and code_ready=0.
- code_out/seq_out when empty: hold last popped value (don't care for checkers; checked only when code_valid=1).
- Simultaneous push and pop when empty: push only (pop needs code_valid=1); occupancy becomes 1.
- Simultaneous push and pop otherwise: occupancy unchanged, both pointers advance.
- Pointers: log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ and low bits equal; empty = equal.
- code_ready with code_valid=0: ignored.
- Reset mid-operation: all contents discarded, overflow_cnt cleared; first post-reset sample gets seq 0.

Decomposition:
- Package adc_ecc_pkg: CODE_W=6, DATA_W=3, function hamming63_encode(data[2:0]) returning codeword[5:0]; reused by the downstream decoder/corrector.
- One sub-module: adc_sync_fifo (parameterised width/depth, push/pop, full/empty), instanced with width CODE_W+SEQ_W. Encoder logic and counters stay in the top.

Test Plan:
- Reset, then single sample binary_in=3'b101, code_ready=1 -> next cycle code_valid=1, code_out=6'b101101, seq_out=0; popped, code_valid=0 following cycle.
- Exhaustive encode: inputs 000, 001, 111 (and all 8) back-to-back, code_ready=1 -> code_out 6'b000000, 6'b000111, 6'b110100, seq_out 0,1,2..., one per cycle, no bubbles after the first.
- Back-pressure: code_ready=0, 6 samples with DEPTH=4 -> fifo_full=1 after 4th, overflow_cnt=2, seq tags 0..3 stored; then code_ready=1 -> 4 codewords in order; next accepted sample gets seq 4.
- Full with simultaneous push+pop -> sample accepted, overflow_cnt unchanged, fifo_full stays 1.
- Saturation/wrap: OVF_W=2 with 5 drops -> overflow_cnt=3; 17 accepted samples with SEQ_W=4 -> 17th carries seq 0.
- Assert rst_n low mid-burst with 3 entries queued -> immediately code_valid=0, overflow_cnt=0; after release, first sample emerges with seq_out=0.

Source files
------------

// File: rtl/adc_ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_ecc_pkg
// Description : Shared Hamming(6,3) widths and encoder for the ADC ECC path.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_ecc_pkg;

  localparam int CODE_W = 6;
  localparam int DATA_W = 3;

  // Codeword layout, position 1..6 = p1 p2 d0 p4 d1 d2 (bit i-1 = position i).
  function automatic logic [CODE_W-1:0] hamming63_encode(input logic [DATA_W-1:0] data);
    logic p1;
    logic p2;
    logic p4;
    p1 = data[0] ^ data[1];
    p2 = data[0] ^ data[2];
    p4 = data[1] ^ data[2];
    return {data[2], data[1], p4, data[0], p2, p1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_sync_fifo
// Description : Single-clock FIFO with extra-MSB pointers; head shown from storage.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO is allowed only when the head leaves the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_hamming_encoder.sv
`default_nettype none
// ============================================================================
// Module      : adc_hamming_encoder
// Description : Encodes ADC samples to Hamming(6,3), tags and queues them.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_hamming_encoder
  import adc_ecc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 4,
  parameter int OVF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] binary_in,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [CODE_W-1:0] code_out,
  output logic [SEQ_W-1:0]  seq_out,
  output logic              fifo_full,
  output logic [OVF_W-1:0]  overflow_cnt
);

  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] seq_d;
  logic [OVF_W-1:0] ovf_q;
  logic [OVF_W-1:0] ovf_d;
  logic             fifo_empty;
  logic             accept;
  logic             drop;

  // When full, code_valid is high, so code_ready alone means a pop this edge.
  assign accept = sample_valid & (~fifo_full | code_ready);
  assign drop   = sample_valid & fifo_full & ~code_ready;

  always_comb begin
    seq_d = seq_q;
    ovf_d = ovf_q;
    if (accept) begin
      seq_d = seq_q + SEQ_W'(1);
    end
    if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= '0;
      ovf_q <= '0;
    end else begin
      seq_q <= seq_d;
      ovf_q <= ovf_d;
    end
  end

  adc_sync_fifo #(
    .WIDTH (CODE_W + SEQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (sample_valid),
    .pop_i   (code_ready),
    .wdata_i ({hamming63_encode(binary_in), seq_q}),
    .rdata_o ({code_out, seq_out}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign code_valid   = ~fifo_empty;
  assign overflow_cnt = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_hamming_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_hamming_encoder
// Description : Directed plus random bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_hamming_encoder;

  localparam int DEPTH = 4;
  localparam int SEQ_W = 4;
  localparam int OVF_W = 8;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic [2:0] binary_in;
  logic       code_valid;
  logic       code_ready;
  logic [5:0] code_out;
  logic [3:0] seq_out;
  logic       fifo_full;
  logic [7:0] overflow_cnt;

  int checks = 0;
  int errors = 0;

  logic [9:0] q[$];
  int         mseq;
  int         movf;

  adc_hamming_encoder #(
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W),
    .OVF_W (OVF_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .binary_in    (binary_in),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .code_out     (code_out),
    .seq_out      (seq_out),
    .fifo_full    (fifo_full),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder from the Hamming rule: parity at position 2^k covers
  // every data position whose index has bit k set.
  function automatic logic [5:0] ref_enc(input logic [2:0] d);
    int         dpos[3];
    logic [6:0] cw;
    dpos[0] = 3; dpos[1] = 5; dpos[2] = 6;
    cw = '0;
    for (int k = 0; k < 3; k++) cw[dpos[k]] = d[k];
    for (int p = 1; p <= 4; p = p * 2) begin
      logic par;
      par = 1'b0;
      for (int k = 0; k < 3; k++)
        if ((dpos[k] & p) != 0) par = par ^ d[k];
      cw[p] = par;
    end
    return cw[6:1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(code_valid), 32'(q.size() != 0));
    chk({tag, ".full"}, 32'(fifo_full), 32'(q.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(overflow_cnt), 32'(movf));
    if (q.size() != 0) begin
      chk({tag, ".code"}, 32'(code_out), 32'(q[0][9:4]));
      chk({tag, ".seq"}, 32'(seq_out), 32'(q[0][3:0]));
    end
  endtask

  // Drive one cycle, update the model at the edge, check just after it.
  task automatic step(input logic sv, input logic [2:0] b, input logic rdy, input string tag);
    bit pop;
    sample_valid = sv;
    binary_in    = b;
    code_ready   = rdy;
    @(posedge clk);
    pop = (q.size() != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (sv) begin
      if (q.size() < DEPTH) begin
        q.push_back({ref_enc(b), 4'(mseq)});
        mseq = (mseq + 1) % (1 << SEQ_W);
      end else if (movf < (1 << OVF_W) - 1) begin
        movf++;
      end
    end
    #1;
    check_model(tag);
  endtask

  task automatic model_reset();
    q.delete();
    mseq = 0;
    movf = 0;
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    binary_in    = 3'b000;
    code_ready   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(code_valid), 0);
    chk("rst.code", 32'(code_out), 0);
    chk("rst.seq", 32'(seq_out), 0);
    chk("rst.full", 32'(fifo_full), 0);
    chk("rst.ovf", 32'(overflow_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single sample latency and explicit codeword.
    step(1'b1, 3'b101, 1'b1, "single");
    chk("single.lit", 32'({code_valid, code_out, seq_out}), 32'({1'b1, 6'b101101, 4'd0}));
    step(1'b0, 3'b000, 1'b1, "single.pop");

    // All eight inputs back to back, no bubbles.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 1'b1, "enc");
      if (i == 1) chk("enc.lit001", 32'(code_out), 32'(6'b000111));
      if (i == 7) chk("enc.lit111", 32'(code_out), 32'(6'b110100));
    end
    step(1'b0, 3'b000, 1'b1, "enc.drain");

    // Back-pressure: six samples into a depth-4 FIFO.
    for (int i = 0; i < 6; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, "bp");
    chk("bp.ovf2", 32'(overflow_cnt), 2);
    chk("bp.full", 32'(fifo_full), 1);

    // Full with simultaneous push and pop.
    step(1'b1, 3'b011, 1'b1, "fullpp");
    chk("fullpp.ovf", 32'(overflow_cnt), 2);
    chk("fullpp.full", 32'(fifo_full), 1);
    for (int i = 0; i < 5; i++) step(1'b0, 3'b000, 1'b1, "bp.drain");

    // Drive the overflow counter to saturation.
    for (int i = 0; i < 4; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, "sat.fill");
    for (int i = 0; i < 260; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, "sat");
    chk("sat.ovf", 32'(overflow_cnt), 255);
    for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b1, "sat.drain");

    // Seventeen accepted samples wrap the sequence tag.
    for (int i = 0; i < 17; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b1, "wrap");

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), "rand");

    // Reset in the middle of a burst with three entries queued.
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000, 1'b1, "pre.drain");
    for (int i = 0; i < 3; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, "midrst.fill");
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.valid", 32'(code_valid), 0);
    chk("midrst.ovf", 32'(overflow_cnt), 0);
    chk("midrst.full", 32'(fifo_full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'b110, 1'b1, "postrst");
    chk("postrst.seq", 32'(seq_out), 0);
    chk("postrst.valid", 32'(code_valid), 1);
    step(1'b0, 3'b000, 1'b1, "postrst.pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
